// File: rtl/pipe_stage_ctx.sv
// pipe_stage_ctx: pipeline stage register with stall/flush and a nested interrupt context stack
// Ports: clk rising-edge clock; reset async active-low; in_data/in_valid upstream payload;
//   stall holds, flush bubbles; int_save pushes the stage and bubbles it; int_restore pops into it;
//   out_data/out_valid registered stage; save_count occupied slots; save_overflow and
//   restore_underflow sticky until reset; restore_parity_err one-cycle pulse on a corrupt pop.
// Optional feature: define PIPE_CTX_PARITY_EN to store and check an even-parity bit per slot.
module pipe_stage_ctx #(
  parameter int WIDTH = 143,
  parameter int SAVE_DEPTH = 4,
  localparam int CW = $clog2(SAVE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             int_save,
  input  logic             int_restore,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    save_count,
  output logic             save_overflow,
  output logic             restore_underflow,
  output logic             restore_parity_err
);
  localparam int IW = SAVE_DEPTH > 1 ? $clog2(SAVE_DEPTH) : 1;
  logic [WIDTH:0] slot_q [SAVE_DEPTH];
  logic [IW-1:0] top;
  logic [WIDTH:0] top_entry, stage_d;
  logic full, empty, push, pop, par_bad;
  assign full = save_count == CW'(SAVE_DEPTH);
  assign empty = save_count == '0;
  // save always wins over a simultaneous restore
  assign push = int_save && !full;
  assign pop = !int_save && int_restore && !empty;
  assign top = IW'(save_count - CW'(1));
  assign top_entry = slot_q[top];
`ifdef PIPE_CTX_PARITY_EN
  logic par_q [SAVE_DEPTH];
  assign par_bad = ^{top_entry, par_q[top]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < SAVE_DEPTH; i++) par_q[i] <= 1'b0;
    else for (int i = 0; i < SAVE_DEPTH; i++) if (push && CW'(i) == save_count) par_q[i] <= ^{out_valid, out_data};
`else
  assign par_bad = 1'b0;
`endif
  // a corrupt entry is replaced by a bubble rather than reaching the next stage
  always_comb
    stage_d = int_save ? '0 :
              int_restore ? (pop && !par_bad ? top_entry : '0) :
              flush ? '0 :
              stall ? {out_valid, out_data} : {in_valid, in_data};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      save_count <= '0;
      save_overflow <= 1'b0;
      restore_underflow <= 1'b0;
      restore_parity_err <= 1'b0;
      for (int i = 0; i < SAVE_DEPTH; i++) slot_q[i] <= '0;
    end else begin
      {out_valid, out_data} <= stage_d;
      save_count <= push ? save_count + CW'(1) : pop ? save_count - CW'(1) : save_count;
      save_overflow <= save_overflow | (int_save & full);
      restore_underflow <= restore_underflow | (!int_save & int_restore & empty);
      restore_parity_err <= pop & par_bad;
      for (int i = 0; i < SAVE_DEPTH; i++) if (push && CW'(i) == save_count) slot_q[i] <= {out_valid, out_data};
    end
endmodule

// File: tb/tb_pipe_stage_ctx.sv
// tb_pipe_stage_ctx: directed and random checks of pipe_stage_ctx against a queue-based model
module tb_pipe_stage_ctx;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] in_data = '0, out_data;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0, int_save = 1'b0, int_restore = 1'b0;
  logic out_valid, save_overflow, restore_underflow, restore_parity_err;
  logic [1:0] save_count;
  int total = 0, bad = 0;
  logic [8:0] stk [$];
  logic mv = 1'b0;
  logic [7:0] md = '0;
  logic movf = 1'b0, munf = 1'b0, mperr = 1'b0, inject = 1'b0;
  pipe_stage_ctx #(.WIDTH(8), .SAVE_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .stall(stall),
    .flush(flush), .int_save(int_save), .int_restore(int_restore), .out_data(out_data),
    .out_valid(out_valid), .save_count(save_count), .save_overflow(save_overflow),
    .restore_underflow(restore_underflow), .restore_parity_err(restore_parity_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_all(string pre);
    chk({pre, "_data"}, 32'(out_data), 32'(md));
    chk({pre, "_valid"}, 32'(out_valid), 32'(mv));
    chk({pre, "_count"}, 32'(save_count), stk.size());
    chk({pre, "_ovf"}, 32'(save_overflow), 32'(movf));
    chk({pre, "_unf"}, 32'(restore_underflow), 32'(munf));
    chk({pre, "_perr"}, 32'(restore_parity_err), 32'(mperr));
  endtask
  task automatic cyc(logic [7:0] d, logic v, logic st, logic fl, logic sv, logic rs);
    logic [8:0] e;
    in_data = d; in_valid = v; stall = st; flush = fl; int_save = sv; int_restore = rs;
    @(posedge clk);
    mperr = 1'b0;
    if (sv) begin
      if (stk.size() < 2) stk.push_back({mv, md});
      else movf = 1'b1;
      {mv, md} = '0;
    end else if (rs) begin
      if (stk.size() > 0) begin
        e = stk.pop_back();
        if (inject) begin
          {mv, md} = '0;
          mperr = 1'b1;
        end else {mv, md} = e;
      end else begin
        munf = 1'b1;
        {mv, md} = '0;
      end
    end else if (fl) {mv, md} = '0;
    else if (!st) {mv, md} = {v, d};
    #1;
    chk_all("cyc");
  endtask
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    stk.delete();
    {mv, md} = '0;
    movf = 1'b0; munf = 1'b0; mperr = 1'b0;
    chk_all("rst");
    @(negedge clk) reset = 1'b1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_all("rst0");
    reset = 1'b1;
    cyc(8'hA5, 1, 0, 0, 0, 0);
    chk("load_a5", 32'(out_data), 32'h0A5);
    chk("load_v", 32'(out_valid), 32'h1);
    cyc(8'h3C, 1, 0, 0, 0, 0);
    cyc(8'hFF, 1, 1, 0, 0, 0);
    chk("stall_hold", 32'(out_data), 32'h03C);
    cyc(8'hFF, 1, 1, 1, 0, 0);
    chk("flush_v", 32'(out_valid), 32'h0);
    chk("flush_d", 32'(out_data), 32'h0);
    cyc(8'h11, 1, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 1, 0);
    cyc(8'h22, 1, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 1, 0);
    chk("nest_cnt2", 32'(save_count), 32'd2);
    chk("nest_bubble", 32'(out_valid), 32'h0);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("nest_r22", 32'(out_data), 32'h022);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("nest_r11", 32'(out_data), 32'h011);
    chk("nest_cnt0", 32'(save_count), 32'd0);
    cyc(8'h01, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 0);
    cyc(8'h02, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 0);
    cyc(8'h03, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 0);
    chk("ovf_flag", 32'(save_overflow), 32'h1);
    chk("ovf_cnt", 32'(save_count), 32'd2);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("ovf_r02", 32'(out_data), 32'h002);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("ovf_r01", 32'(out_data), 32'h001);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("unf_flag", 32'(restore_underflow), 32'h1);
    chk("unf_bubble", 32'(out_valid), 32'h0);
    do_reset();
    cyc(8'h55, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 0);
    cyc(8'h77, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 1);
    chk("sim_cnt", 32'(save_count), 32'd2);
    chk("sim_bubble", 32'(out_valid), 32'h0);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("sim_top77", 32'(out_data), 32'h077);
    cyc(8'h00, 0, 0, 0, 0, 1);
    chk("sim_next55", 32'(out_data), 32'h055);
    cyc(8'hC3, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 0);
    do_reset();
    chk("rst_mid_cnt", 32'(save_count), 32'd0);
`ifdef PIPE_CTX_PARITY_EN
    begin
      logic p;
      cyc(8'h5A, 1, 0, 0, 0, 0); cyc(8'h00, 0, 0, 0, 1, 0);
      p = dut.par_q[0];
      force dut.par_q[0] = ~p;
      inject = 1'b1;
      cyc(8'h00, 0, 0, 0, 0, 1);
      inject = 1'b0;
      release dut.par_q[0];
      chk("par_err", 32'(restore_parity_err), 32'h1);
      chk("par_bubble", 32'(out_valid), 32'h0);
      cyc(8'h12, 1, 0, 0, 0, 0);
      chk("par_pulse", 32'(restore_parity_err), 32'h0);
    end
`endif
    for (int i = 0; i < 600; i++)
      if (i % 150 == 149) do_reset();
      else cyc(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
